wb_result_stage: RTL and testbench
==================================

// Module: wb_result_stage
// PURPOSE
//  Registered, parametrised write-back stage for the RV32 core. Selects the register-file
//  write value among ALU, load data, PC+PC_INC, AUIPC and LUI immediate.
//  Aligns and sign/zero-extends load data (LB/LH/LW/LBU/LHU) and stalls upstream until
//  the memory returns data. Sits between the MEM stage and the register file.
// PARAMETERS
//  XLEN    32  datapath width (32 or 64; loads extend to XLEN)
//  RIDX_W  5   register index width
//  PC_INC  4   link increment added to PC for JAL/JALR
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  in_valid    in   1       upstream instruction valid
//  in_ready    out  1       stage can accept (combinational, = state==IDLE)
//  in_sel      in   3       0 ALU, 1 LOAD, 2 PC+PC_INC, 3 AUIPC, 4 LUI imm, 5-7 reserved
//  in_funct3   in   3       load type: 000 LB 001 LH 010 LW 100 LBU 101 LHU, others reserved
//  in_addr_lo  in   2       load byte address [1:0]
//  in_rd       in   RIDX_W  destination register
//  in_pc       in   XLEN    instruction PC
//  in_alu      in   XLEN    ALU result
//  in_auipc    in   XLEN    AUIPC result
//  in_imm      in   XLEN    LUI immediate (already shifted)
//  mem_rvalid  in   1       load data valid this cycle
//  mem_rdata   in   32      raw aligned word from data memory
//  rf_we       out  1       register-file write enable (one-cycle pulse)
//  rf_waddr    out  RIDX_W  write index
//  rf_wdata    out  XLEN    write data
//  wb_err      out  1       one-cycle pulse: reserved sel/funct3 accepted
// BEHAVIOUR
//  Reset: state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, wb_err=0; pending load dropped.
//  FSM IDLE/WAIT_MEM. Accept = in_valid && in_ready. All outputs are registered.
//  IDLE, accept, sel!=LOAD: next cycle rf_we=1, rf_wdata=selected value; latency 1;
//   back-to-back accepts every cycle allowed.
//  IDLE, accept, sel==LOAD, mem_rvalid=1 same cycle: write next cycle, stay IDLE.
//  IDLE, accept, sel==LOAD, mem_rvalid=0: capture rd/funct3/addr_lo -> WAIT_MEM;
//   in_ready=0. Cycle after first mem_rvalid: write extended data, -> IDLE.
//  mem_rvalid in IDLE without LOAD accept: ignored.
//  PC+PC_INC: wraps modulo 2^XLEN (pc=all-ones, PC_INC=4 -> 3).
//  Load extract: LB/LBU byte = mem_rdata[8*addr_lo +: 8]; LH/LHU half from addr_lo[1]
//   (addr_lo[0] ignored); LW ignores addr_lo; XLEN=64 LW sign-extends.
//  Signed loads replicate the MSB up to XLEN; unsigned loads zero-fill.
//  rd==0: rf_we stays 0, but the stage still takes the normal cycles (incl. load wait).
//  Reserved sel or reserved funct3 on LOAD: rf_we=0, wb_err=1 for one cycle, no WAIT_MEM.
//  rf_we=0 on cycles with no write; rf_waddr/rf_wdata hold last written values.
//  Async reset mid-WAIT_MEM: immediate IDLE, outputs cleared, no write after release.
// TESTING
//  ALU sel, in_alu=0x1234, rd=5 -> next cycle rf_we=1, waddr=5, wdata=0x00001234.
//  LB, addr_lo=2, mem_rdata=0x00800000 same cycle -> wdata=0xFFFFFF80; LBU -> 0x00000080.
//  LH addr_lo=2, mem_rvalid 3 cycles late, rdata=0x8001_0000 -> in_ready low 3 cycles,
//   then wdata=0xFFFF8001.
//  JAL sel, pc=0xFFFFFFFC, rd=1 -> wdata=0x00000000. Same with rd=0 -> rf_we stays 0.
//  sel=6 -> wb_err pulse, rf_we=0; funct3=011 LOAD -> wb_err, in_ready stays 1.
//  rst_n low during WAIT_MEM, then mem_rvalid after release -> no rf_we, in_ready=1.

Source files
------------

// File: rtl/wb_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_result_stage
//  Description : Registered write-back stage for the RV32 core.
//                It chooses the register-file write value from these sources:
//                ALU result, load data, PC+PC_INC, AUIPC result or LUI
//                immediate. Load data is aligned, then sign- or zero-extended.
//                When a load accepts before its data is back, the stage holds
//                upstream off until the memory returns the data.
//  Ports       : clk, rst_n (async, active-low)
//                in_valid/in_ready   - upstream handshake (in_ready = IDLE)
//                in_sel, in_funct3, in_addr_lo, in_rd, in_pc, in_alu,
//                in_auipc, in_imm    - instruction results and control
//                mem_rvalid/mem_rdata - data-memory read return
//                rf_we/rf_waddr/rf_wdata - register-file write port
//                wb_err              - pulse for a reserved sel/funct3 accept
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_result_stage #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5,
    parameter int PC_INC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_sel,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic [RIDX_W-1:0] in_rd,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_auipc,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rf_we,
    output logic [RIDX_W-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              wb_err
);

    localparam logic [0:0] c_ST_IDLE     = 1'b0;
    localparam logic [0:0] c_ST_WAIT_MEM = 1'b1;

    localparam logic [2:0] c_SEL_ALU   = 3'd0;
    localparam logic [2:0] c_SEL_LOAD  = 3'd1;
    localparam logic [2:0] c_SEL_LINK  = 3'd2;
    localparam logic [2:0] c_SEL_AUIPC = 3'd3;
    localparam logic [2:0] c_SEL_LUI   = 3'd4;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    logic [0:0]        r_state;
    logic [RIDX_W-1:0] r_ld_rd;
    logic [2:0]        r_ld_funct3;
    logic [1:0]        r_ld_addr_lo;
    logic              r_rf_we;
    logic [RIDX_W-1:0] r_rf_waddr;
    logic [XLEN-1:0]   r_rf_wdata;
    logic              r_wb_err;

    logic              w_accept;
    logic              w_sel_reserved;
    logic              w_f3_valid;
    logic [XLEN-1:0]   w_sel_value;
    logic [XLEN-1:0]   w_load_now;
    logic [XLEN-1:0]   w_load_wait;

    // Pick the byte or halfword that the load addresses out of the word.
    // Then extend it to XLEN. A halfword uses only addr_lo[1]. LW ignores
    // addr_lo, and it still sign-extends when XLEN is wider than 32.
    function automatic logic [XLEN-1:0] load_extend(
        input logic [2:0]  f3,
        input logic [1:0]  lo,
        input logic [31:0] word
    );
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        logic [XLEN-1:0] v_res;
        case (lo)
            2'd0:    v_byte = word[7:0];
            2'd1:    v_byte = word[15:8];
            2'd2:    v_byte = word[23:16];
            default: v_byte = word[31:24];
        endcase
        v_half = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            c_F3_LB:  v_res = XLEN'($signed(v_byte));
            c_F3_LH:  v_res = XLEN'($signed(v_half));
            c_F3_LW:  v_res = XLEN'($signed(word));
            c_F3_LBU: v_res = XLEN'(v_byte);
            c_F3_LHU: v_res = XLEN'(v_half);
            default:  v_res = '0;
        endcase
        return v_res;
    endfunction

    assign in_ready = (r_state == c_ST_IDLE);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_sel_reserved = (in_sel > c_SEL_LUI);
        w_f3_valid     = (in_funct3 == c_F3_LB)  || (in_funct3 == c_F3_LH) ||
                         (in_funct3 == c_F3_LW)  || (in_funct3 == c_F3_LBU) ||
                         (in_funct3 == c_F3_LHU);
        w_load_now     = load_extend(in_funct3, in_addr_lo, mem_rdata);
        w_load_wait    = load_extend(r_ld_funct3, r_ld_addr_lo, mem_rdata);
        case (in_sel)
            c_SEL_LOAD:  w_sel_value = w_load_now;
            c_SEL_LINK:  w_sel_value = in_pc + XLEN'(PC_INC);  // wraps modulo 2^XLEN
            c_SEL_AUIPC: w_sel_value = in_auipc;
            c_SEL_LUI:   w_sel_value = in_imm;
            default:     w_sel_value = in_alu;
        endcase
    end

    // rf_waddr and rf_wdata change only on a real write. Between writes they
    // keep the last written values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_ld_rd      <= '0;
            r_ld_funct3  <= '0;
            r_ld_addr_lo <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_wb_err     <= 1'b0;
        end else begin
            r_rf_we  <= 1'b0;
            r_wb_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_sel_reserved || ((in_sel == c_SEL_LOAD) && !w_f3_valid)) begin
                            r_wb_err <= 1'b1;
                        end else if ((in_sel == c_SEL_LOAD) && !mem_rvalid) begin
                            r_ld_rd      <= in_rd;
                            r_ld_funct3  <= in_funct3;
                            r_ld_addr_lo <= in_addr_lo;
                            r_state      <= c_ST_WAIT_MEM;
                        end else if (in_rd != '0) begin
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= in_rd;
                            r_rf_wdata <= w_sel_value;
                        end
                    end
                end
                c_ST_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        r_state <= c_ST_IDLE;
                        // A load to x0 still waits for its data, but it does not write.
                        if (r_ld_rd != '0) begin
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= r_ld_rd;
                            r_rf_wdata <= w_load_wait;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign wb_err   = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_result_stage
//  Description : Testbench for wb_result_stage, using directed vectors
//                (XLEN=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [4:0]  in_rd;
    logic [31:0] in_pc;
    logic [31:0] in_alu;
    logic [31:0] in_auipc;
    logic [31:0] in_imm;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    logic [4:0]  hold_waddr;
    logic [31:0] hold_wdata;

    wb_result_stage #(.XLEN(32), .RIDX_W(5), .PC_INC(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .in_rd      (in_rd),
        .in_pc      (in_pc),
        .in_alu     (in_alu),
        .in_auipc   (in_auipc),
        .in_imm     (in_imm),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .wb_err     (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] auipc;
        logic [31:0] imm;
        logic [31:0] rdata;
        logic        rvalid;
        logic        exp_we;
        logic        exp_err;
        logic [31:0] exp_wdata;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_we, input logic exp_err,
                                 input logic exp_ready);
        check({tag, " rf_we"},    32'(rf_we),    32'(exp_we));
        check({tag, " wb_err"},   32'(wb_err),   32'(exp_err));
        check({tag, " in_ready"}, 32'(in_ready), 32'(exp_ready));
        check({tag, " rf_waddr"}, 32'(rf_waddr), 32'(hold_waddr));
        check({tag, " rf_wdata"}, rf_wdata,      hold_wdata);
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_sel     = 3'd0;
        in_funct3  = 3'd0;
        in_addr_lo = 2'd0;
        in_rd      = 5'd0;
        in_pc      = 32'h0;
        in_alu     = 32'h0;
        in_auipc   = 32'h0;
        in_imm     = 32'h0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            sel   f3      lo    rd     pc            alu           auipc         imm           rdata         rv    we    err   wdata
        vecs[0]  = '{3'd0, 3'b000, 2'd0, 5'd5,  32'h0,        32'h00001234, 32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h00001234};
        vecs[1]  = '{3'd1, 3'b000, 2'd2, 5'd6,  32'h0,        32'h0,        32'h0,        32'h0,        32'h00800000, 1'b1, 1'b1, 1'b0, 32'hFFFFFF80};
        vecs[2]  = '{3'd1, 3'b100, 2'd2, 5'd7,  32'h0,        32'h0,        32'h0,        32'h0,        32'h00800000, 1'b1, 1'b1, 1'b0, 32'h00000080};
        vecs[3]  = '{3'd2, 3'b000, 2'd0, 5'd1,  32'hFFFFFFFC, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h00000000};
        vecs[4]  = '{3'd2, 3'b000, 2'd0, 5'd0,  32'hFFFFFFFC, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{3'd6, 3'b000, 2'd0, 5'd9,  32'h0,        32'h11111111, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
        vecs[6]  = '{3'd1, 3'b011, 2'd0, 5'd9,  32'h0,        32'h0,        32'h0,        32'h0,        32'h12345678, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{3'd3, 3'b000, 2'd0, 5'd31, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[8]  = '{3'd4, 3'b000, 2'd0, 5'd2,  32'h0,        32'h0,        32'h0,        32'hABCDE000, 32'h0,        1'b0, 1'b1, 1'b0, 32'hABCDE000};
        vecs[9]  = '{3'd1, 3'b001, 2'd1, 5'd3,  32'h0,        32'h0,        32'h0,        32'h0,        32'h1234F00D, 1'b1, 1'b1, 1'b0, 32'hFFFFF00D};
        vecs[10] = '{3'd1, 3'b101, 2'd3, 5'd4,  32'h0,        32'h0,        32'h0,        32'h0,        32'h80017FFF, 1'b1, 1'b1, 1'b0, 32'h00008001};
        vecs[11] = '{3'd1, 3'b010, 2'd3, 5'd8,  32'h0,        32'h0,        32'h0,        32'h0,        32'h87654321, 1'b1, 1'b1, 1'b0, 32'h87654321};
        vecs[12] = '{3'd1, 3'b000, 2'd3, 5'd9,  32'h0,        32'h0,        32'h0,        32'h0,        32'h7F000000, 1'b1, 1'b1, 1'b0, 32'h0000007F};
        vecs[13] = '{3'd1, 3'b100, 2'd0, 5'd10, 32'h0,        32'h0,        32'h0,        32'h0,        32'h000000FF, 1'b1, 1'b1, 1'b0, 32'h000000FF};
        vecs[14] = '{3'd1, 3'b000, 2'd1, 5'd11, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0000FF00, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF};
        vecs[15] = '{3'd7, 3'b000, 2'd0, 5'd12, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
        vecs[16] = '{3'd2, 3'b000, 2'd0, 5'd12, 32'h00000100, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h00000104};
        vecs[17] = '{3'd0, 3'b000, 2'd0, 5'd13, 32'h0,        32'hCAFEF00D, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D};

        idle_inputs();
        hold_waddr = 5'd0;
        hold_wdata = 32'h0;
        rst_n = 1'b0;
        tick();
        tick();
        check_outputs("reset", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_outputs("post-reset idle", 1'b0, 1'b0, 1'b1);

        // Back-to-back single-cycle transactions
        for (int i = 0; i < NVEC; i++) begin
            in_valid   = 1'b1;
            in_sel     = vecs[i].sel;
            in_funct3  = vecs[i].f3;
            in_addr_lo = vecs[i].lo;
            in_rd      = vecs[i].rd;
            in_pc      = vecs[i].pc;
            in_alu     = vecs[i].alu;
            in_auipc   = vecs[i].auipc;
            in_imm     = vecs[i].imm;
            mem_rdata  = vecs[i].rdata;
            mem_rvalid = vecs[i].rvalid;
            tick();
            if (vecs[i].exp_we) begin
                hold_waddr = vecs[i].rd;
                hold_wdata = vecs[i].exp_wdata;
            end
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_err, 1'b1);
        end
        idle_inputs();
        tick();
        check_outputs("idle after vectors", 1'b0, 1'b0, 1'b1);

        // A stray mem_rvalid in IDLE is ignored
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55555555;
        tick();
        check_outputs("stray rvalid", 1'b0, 1'b0, 1'b1);
        idle_inputs();

        // LH, addr_lo=2, data arrives three cycles late
        in_valid = 1'b1; in_sel = 3'd1; in_funct3 = 3'b001; in_addr_lo = 2'd2; in_rd = 5'd14;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            check_outputs($sformatf("lh wait%0d", k), 1'b0, 1'b0, 1'b0);
            tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80010000;
        tick();
        mem_rvalid = 1'b0;
        hold_waddr = 5'd14;
        hold_wdata = 32'hFFFF8001;
        check_outputs("lh late data", 1'b1, 1'b0, 1'b1);

        // A load to x0 still waits, but it does not write
        in_valid = 1'b1; in_sel = 3'd1; in_funct3 = 3'b010; in_addr_lo = 2'd0; in_rd = 5'd0;
        tick();
        idle_inputs();
        check_outputs("x0 load wait", 1'b0, 1'b0, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h13572468;
        tick();
        mem_rvalid = 1'b0;
        check_outputs("x0 load done", 1'b0, 1'b0, 1'b1);

        // Asynchronous reset while in WAIT_MEM
        in_valid = 1'b1; in_sel = 3'd1; in_funct3 = 3'b000; in_addr_lo = 2'd1; in_rd = 5'd15;
        tick();
        idle_inputs();
        check_outputs("pre-reset wait", 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        hold_waddr = 5'd0;
        hold_wdata = 32'h0;
        check_outputs("async reset", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000AA00;
        tick();
        mem_rvalid = 1'b0;
        check_outputs("rvalid after reset", 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
